// File: rtl/shift_combine.sv
// shift_combine: oversampling serial receiver (start 0, DATA_WIDTH bits LSB-first, stop 1).
// Recovers words from the idle-high line and hands them to the consumer with a valid/ack handshake.
//
// Handshake (data_valid / rx_ack):
//   data_valid rises on the edge that loads data_received and stays high until an edge with rx_ack = 1.
//   If rx_ack is high on an edge without a load, data_valid and overrun clear on that edge.
//   If a load happens while data_valid is already high and rx_ack is low, data_received is overwritten
//   and overrun is set.
//   If a load and rx_ack land on the same edge, the load wins: data_valid stays 1 and overrun is 0.
//   rx_ack is honoured on every clk edge, independent of enable_s.
`timescale 1ns/1ps
module shift_combine #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_s,
    input  logic                  bit_in,
    input  logic                  rx_ack,
    output logic [DATA_WIDTH-1:0] data_received,
    output logic                  data_valid,
    output logic                  rx_busy,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    // START samples on the tick that takes the counter to OVERSAMPLE/2; DATA/STOP on OVERSAMPLE.
    // The counter is compared one step early so it never has to hold OVERSAMPLE itself.
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // State is kept as a named flop so checkers can bind to it directly.
    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  frame_error_q, frame_error_d;
    logic                  overrun_q, overrun_d;

    logic                  bit_s;
    logic                  load;
    logic [DATA_WIDTH:0]   shift_cat;

    assign bit_s     = sync_q[1];
    assign shift_cat = {bit_s, shift_q};

    // Two-flop synchronizer for the asynchronous line; bit_in enters at bit 0.
    always_comb begin
        sync_d = {sync_q[0], bit_in};
    end

    // Frame FSM: advances only on ticks; decides every sample from the synchronized line.
    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        frame_error_d = frame_error_q;
        load          = 1'b0;
        if (enable_s) begin
            case (state_q)
                S_IDLE: begin
                    if (!bit_s) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!bit_s) begin
                            state_d   = S_DATA;
                            bit_idx_d = '0;
                        end else begin
                            // Start bit did not survive to mid-bit: treat as a glitch.
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        shift_d   = shift_cat[DATA_WIDTH:1];
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (bit_s) begin
                            load          = 1'b1;
                            frame_error_d = 1'b0;
                            state_d       = S_IDLE;
                        end else begin
                            frame_error_d = 1'b1;
                            state_d       = S_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Wait for the line to return high so a held-low line is not a new start bit.
                    if (bit_s) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

    // Output handshake: load beats ack, ack clears valid/overrun on any edge.
    always_comb begin
        data_d    = load ? shift_q : data_q;
        valid_d   = load | (valid_q & ~rx_ack);
        overrun_d = ~rx_ack & (overrun_q | (load & valid_q));
        busy_d    = (state_d != S_IDLE);
    end

    // All state registers; synchronous reset overrides everything, including mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sync_q        <= 2'b11;
            tick_q        <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            tick_q        <= tick_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_received = data_q;
    assign data_valid    = valid_q;
    assign rx_busy       = busy_q;
    assign frame_error   = frame_error_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_shift_combine.sv
// tb_shift_combine: directed frames through shift_combine with a word scoreboard.
`timescale 1ns/1ps
module tb_shift_combine;

    localparam int DW = 8;
    localparam int OS = 16;
    localparam int TW = $clog2(OS);
    localparam int BW = $clog2(DW + 1);

    logic          clk;
    logic          rst;
    logic          enable_s;
    logic          bit_in;
    logic          rx_ack;
    logic [DW-1:0] data_received;
    logic          data_valid;
    logic          rx_busy;
    logic          frame_error;
    logic          overrun;

    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            en_cnt   = 0;

    shift_combine #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_s      (enable_s),
        .bit_in        (bit_in),
        .rx_ack        (rx_ack),
        .data_received (data_received),
        .data_valid    (data_valid),
        .rx_busy       (rx_busy),
        .frame_error   (frame_error),
        .overrun       (overrun)
    );

    // Clock and oversample strobe (every 3rd clk, updated away from both edges).
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        enable_s = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            en_cnt   = (en_cnt == 2) ? 0 : en_cnt + 1;
            enable_s = (en_cnt == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Hold the line at b for n ticks; optionally raise rx_ack only on the stop-sample edge.
    task automatic drive_bit(input logic b, input int n, input bit ack_load);
        int cnt;
        cnt = 0;
        @(negedge clk);
        bit_in = b;
        while (cnt < n) begin
            if (ack_load)
                rx_ack = rx_busy && (dut.bit_idx_q == BW'(DW)) &&
                         (dut.tick_q == TW'(OS - 1)) && enable_s;
            @(posedge clk);
            if (enable_s) cnt++;
            @(negedge clk);
        end
        if (ack_load) rx_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic stop, input bit ack_load);
        if (stop) exp_q.push_back(data);
        drive_bit(1'b0, OS, 1'b0);
        for (int i = 0; i < DW; i++) drive_bit(data[i], OS, 1'b0);
        drive_bit(stop, OS, ack_load);
    endtask

    task automatic check_word(input string tag);
        logic [DW-1:0] exp;
        check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check({tag, "_data"}, 32'(data_received), 32'(exp));
            check({tag, "_valid"}, 32'(data_valid), 32'd1);
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},    32'(data_received), 32'd0);
        check({tag, "_valid"},   32'(data_valid),    32'd0);
        check({tag, "_busy"},    32'(rx_busy),       32'd0);
        check({tag, "_ferr"},    32'(frame_error),   32'd0);
        check({tag, "_overrun"}, 32'(overrun),       32'd0);
    endtask

    initial begin
        logic busy_seen;
        rst    = 1'b1;
        bit_in = 1'b1;
        rx_ack = 1'b0;

        // 1. Reset and idle line
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst       = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do @(posedge clk); while (!enable_s);
            @(negedge clk);
            busy_seen = busy_seen | rx_busy;
        end
        check("idle_busy", 32'(busy_seen), 32'd0);

        // 2. Good frame, then ack
        send_frame(8'hD3, 1'b1, 1'b0);
        check_word("good_d3");
        check("good_d3_ferr", 32'(frame_error), 32'd0);
        check("good_d3_overrun", 32'(overrun), 32'd0);
        ack_pulse();
        check("ack_d3_valid", 32'(data_valid), 32'd0);
        check("ack_d3_data_kept", 32'(data_received), 32'hD3);

        // 3. Glitch on the start bit, then a clean frame
        drive_bit(1'b0, 4, 1'b0);
        check("glitch_busy", 32'(rx_busy), 32'd1);
        drive_bit(1'b1, 10, 1'b0);
        check("glitch_idle", 32'(rx_busy), 32'd0);
        check("glitch_valid", 32'(data_valid), 32'd0);
        drive_bit(1'b1, 4, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        check_word("after_glitch_5a");
        ack_pulse();

        // 4. Framing error with the line held low, then recovery
        send_frame(8'h55, 1'b0, 1'b0);
        check("ferr_set", 32'(frame_error), 32'd1);
        check("ferr_valid", 32'(data_valid), 32'd0);
        check("ferr_data_kept", 32'(data_received), 32'h5A);
        drive_bit(1'b0, 40, 1'b0);
        check("break_busy", 32'(rx_busy), 32'd1);
        check("break_valid", 32'(data_valid), 32'd0);
        check("break_ferr", 32'(frame_error), 32'd1);
        drive_bit(1'b1, 6, 1'b0);
        check("break_exit", 32'(rx_busy), 32'd0);
        check("ferr_sticky_idle", 32'(frame_error), 32'd1);
        send_frame(8'hA5, 1'b1, 1'b0);
        check_word("recover_a5");
        check("recover_ferr", 32'(frame_error), 32'd0);
        ack_pulse();

        // 5. Overrun, ack clears, then ack on the load edge
        send_frame(8'h3C, 1'b1, 1'b0);
        check_word("ovr_3c");
        check("ovr_3c_overrun", 32'(overrun), 32'd0);
        send_frame(8'hC3, 1'b1, 1'b0);
        check_word("ovr_c3");
        check("ovr_c3_overrun", 32'(overrun), 32'd1);
        ack_pulse();
        check("ovr_ack_valid", 32'(data_valid), 32'd0);
        check("ovr_ack_overrun", 32'(overrun), 32'd0);
        send_frame(8'h7E, 1'b1, 1'b0);
        check_word("pre_7e");
        send_frame(8'h81, 1'b1, 1'b1);
        check_word("ack_on_load_81");
        check("ack_on_load_overrun", 32'(overrun), 32'd0);

        // 6. Reset during data bit 4, then a clean frame
        drive_bit(1'b0, OS, 1'b0);
        drive_bit(1'b1, OS, 1'b0);
        drive_bit(1'b0, OS, 1'b0);
        drive_bit(1'b0, OS, 1'b0);
        drive_bit(1'b0, OS, 1'b0);
        drive_bit(1'b0, 8, 1'b0);
        check("mid_busy", 32'(rx_busy), 32'd1);
        rst    = 1'b1;
        bit_in = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst = 1'b0;
        drive_bit(1'b1, 5, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        check_word("post_reset_81");
        check("post_reset_ferr", 32'(frame_error), 32'd0);
        check("post_reset_overrun", 32'(overrun), 32'd0);
        ack_pulse();
        check("final_valid", 32'(data_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
